// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_timer
// Purpose  : Loadable down-counter/timer with IDLE/RUN control, one-shot or
//            periodic auto-reload and a registered terminal-count pulse.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
  parameter int                     COUNT_WIDTH = 8,
  parameter logic [COUNT_WIDTH-1:0] COUNT_FROM  = COUNT_WIDTH'((2**COUNT_WIDTH)-1),
  parameter logic [COUNT_WIDTH-1:0] COUNT_TO    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   en,
  input  logic                   oneshot,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   tc,
  output logic                   busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] reload_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   tc_q;
  logic                   busy_q;
  logic                   w_at_term;

  // Written as "not above" so a reload below COUNT_TO also fires terminal
  assign w_at_term = ~(count_q > COUNT_TO);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      reload_q <= COUNT_FROM;
      count_q  <= COUNT_FROM;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else if (load) begin
      state_q  <= S_IDLE;
      reload_q <= load_value;
      count_q  <= load_value;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else if (stop) begin
      state_q <= S_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tc_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!en) begin
            tc_q <= 1'b0;
          end else if (w_at_term) begin
            count_q <= reload_q;
            tc_q    <= 1'b1;
            if (oneshot) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            count_q <= count_q - 1'b1;
            tc_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tc_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter/timer: counts from a programmable reload value down to a terminal value, then flags terminal count.
- Complement to the up-counter; used for timeouts, periodic ticks and delay generation.
- One-shot and periodic (auto-reload) modes, with an explicit IDLE/RUN state machine and start/stop/load control.

Parameters:
- COUNT_WIDTH, 8, count/reload bit width.
- COUNT_FROM, (2**COUNT_WIDTH)-1, reload value after reset. Must be >= COUNT_TO.
- COUNT_TO, 0, terminal value; the count never decrements below it.

Ports:
- clk  input  1  counter clock.
- rst  input  1  reset, synchronous, active-low: sampled only on posedge clk, and a sampled 0 resets.
- load  input  1  capture load_value into reload register and count.
- load_value  input  COUNT_WIDTH  new reload value.
- start  input  1  begin counting (IDLE -> RUN).
- stop  input  1  halt counting (RUN -> IDLE); count is held.
- en  input  1  count enable / tick qualifier while in RUN.
- oneshot  input  1  1 = return to IDLE after terminal count; 0 = periodic auto-reload.
- count  output  COUNT_WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- busy  output  1  high while in RUN.

Behaviour:
- State machine: IDLE, RUN. All outputs are registered. All actions take effect on posedge clk.
- Priority per edge: rst==0 > load > stop > start > count/terminal logic.
- Reset (rst==0 at posedge clk):
  - reload register = COUNT_FROM, count = COUNT_FROM.
  - tc = 0, busy = 0, state = IDLE.
- load:
  - reload register and count take load_value; state = IDLE; busy = 0; tc = 0.
  - Aborts a run in progress.
- stop: RUN -> IDLE; busy = 0; count held; tc = 0. In IDLE it has no effect.
- start in IDLE: -> RUN; busy = 1 from the next cycle; count unchanged on that edge.
  - start while in RUN is ignored and does not restart.
- RUN, en==0: count and state held; tc = 0.
- RUN, en==1, count > COUNT_TO: count <= count - 1; tc = 0.
- RUN, en==1, count <= COUNT_TO (terminal):
  - count <= reload register; tc = 1 for exactly this one cycle.
  - If oneshot==1: state -> IDLE, busy = 0. If oneshot==0: stay in RUN.
- The <= comparison covers load_value < COUNT_TO: the first enabled edge fires terminal, with no underflow or wrap below COUNT_TO.
- Period: with reload R and en held high, tc pulses every (R - COUNT_TO + 1) cycles.
  - R == COUNT_TO gives tc on every cycle in periodic mode.
- oneshot is sampled only on the terminal edge; changing it mid-run is legal.
- tc is never asserted in IDLE and never on a load/stop/reset edge.
- Arithmetic is unsigned, COUNT_WIDTH bits, with no carry-out.

Test Plan:
- Reset: drive rst=0 for 2 edges with load/start active -> count=255, tc=0, busy=0. Release, hold 3 idle edges -> count stays 255.
- Periodic, W=8: load 3, start, en=1, oneshot=0 -> count 3,2,1,0, then tc=1 with count=3 on the next edge. Pattern repeats; tc every 4 cycles, busy stays 1.
- One-shot plus gaps: load 2, start, oneshot=1, en toggled 1,0,1,1 -> count 2,1,1,0. On the next en edge: tc=1, count=2, busy=0. Further en gives no change and no tc.
- Control priority, mid-run at count=5:
  - assert stop -> count held at 5, busy=0.
  - start -> resumes 4,3.
  - load 9 together with start -> count=9, state IDLE, busy=0.
  - rst=0 together with load -> count=COUNT_FROM.
- Boundary, COUNT_TO=2: load 1, start, en=1 -> the first enabled edge gives tc=1, count=1. No wrap to 255.
